// File: rtl/data_demod.sv
// data_demod: packs the 5-bit symbol stream LSB-first into bytes and buffers them in a show-ahead FIFO
module data_demod #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mod_en,
  input  logic [4:0]  dmod,
  input  logic        rd,
  output logic        rdy,
  output logic [7:0]  data_out,
  output logic [AW:0] level,
  output logic        ovf
);
  logic [11:0]   r_acc;
  logic [2:0]    r_res;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;
  logic [7:0]    r_dout;
  logic          r_ovf;
  logic [11:0]   w_next;
  logic [3:0]    w_tot;
  logic [AW-1:0] w_rp1;
  logic          w_done, w_pop, w_full, w_push;
  assign w_next = r_acc | ({7'd0, dmod} << r_res);
  assign w_tot = {1'b0, r_res} + 4'd5;
  assign w_done = mod_en & w_tot[3];
  assign w_pop = rd & rdy;
  assign w_full = r_level == (AW+1)'(DEPTH);
  assign w_push = w_done & (~w_full | w_pop);
  assign w_rp1 = r_rp + 1'b1;
  assign rdy = r_level != '0;
  assign data_out = r_dout;
  assign level = r_level;
  assign ovf = r_ovf;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_acc <= '0;
      r_res <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_level <= '0;
      r_dout <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (mod_en) begin
        r_acc <= w_done ? {8'd0, w_next[11:8]} : w_next;
        // tot never exceeds 12, so tot and tot-8 share their low three bits
        r_res <= w_tot[2:0];
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= w_rp1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_done & w_full & ~w_pop) r_ovf <= 1'b1;
      // head after the edge: next stored entry, else the byte landing in an emptied FIFO, else hold
      if (w_pop & |r_level[AW:1]) r_dout <= r_mem[w_rp1];
      else if (w_push & (~rdy | w_pop)) r_dout <= w_next[7:0];
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_next[7:0];
endmodule

// File: tb/tb_data_demod.sv
// tb_data_demod: directed vector table, multi-cycle corner sequences and a random stream checked against a bit-packer model
module tb_data_demod;
  localparam int DEPTH = 8;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mod_en = 1'b0;
  logic [4:0] dmod = 5'd0;
  logic       rd = 1'b0;
  logic       rdy;
  logic [7:0] data_out;
  logic [3:0] level;
  logic       ovf;
  int n_chk = 0;
  int n_err = 0;
  bit [7:0] m_q[$];
  int       m_acc = 0;
  int       m_cnt = 0;
  logic [7:0] m_last = 8'h00;
  logic       m_ovf = 1'b0;

  typedef struct {
    logic       rn, me;
    logic [4:0] d;
    logic       r;
    logic       e_rdy;
    logic [7:0] e_dout;
    logic [3:0] e_lvl;
    logic       e_ovf;
  } vec_t;
  vec_t v[$];

  data_demod #(.DEPTH(8), .AW(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .mod_en(mod_en), .dmod(dmod), .rd(rd),
    .rdy(rdy), .data_out(data_out), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic rn, input logic me, input logic [4:0] d, input logic r);
    bit pop, done;
    logic [7:0] b;
    if (!rn) begin
      m_q.delete();
      m_acc = 0;
      m_cnt = 0;
      m_last = 8'h00;
      m_ovf = 1'b0;
      return;
    end
    pop = r && m_q.size() > 0;
    done = 0;
    b = 8'h00;
    if (me) begin
      m_acc = m_acc | (int'(d) << m_cnt);
      m_cnt += 5;
      if (m_cnt >= 8) begin
        b = m_acc[7:0];
        m_acc = m_acc >> 8;
        m_cnt -= 8;
        done = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (done) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovf = 1'b1;
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic step(input logic rn, input logic me, input logic [4:0] d, input logic r);
    reset_n = rn;
    mod_en = me;
    dmod = d;
    rd = r;
    @(posedge clk);
    model(rn, me, d, r);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " rdy"}, 32'(rdy), 32'(m_q.size() > 0));
    chk({nm, " data_out"}, 32'(data_out), 32'(m_last));
    chk({nm, " level"}, 32'(level), 32'(m_q.size()));
    chk({nm, " ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  task automatic add(input logic rn, input logic me, input logic [4:0] d, input logic r,
                     input logic e_rdy, input logic [7:0] e_dout, input logic [3:0] e_lvl, input logic e_ovf);
    v.push_back('{rn, me, d, r, e_rdy, e_dout, e_lvl, e_ovf});
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 5'($urandom_range(0, 31)), 1'b0);
      chk("reset rdy", 32'(rdy), 32'd0);
      chk("reset level", 32'(level), 32'd0);
      chk("reset ovf", 32'(ovf), 32'd0);
      chk("reset data_out", 32'(data_out), 32'd0);
    end
    // single byte, rd ignored while empty, pop, underflow
    add(1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    add(1'b1, 1'b1, 5'h05, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    add(1'b1, 1'b1, 5'h05, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0);
    add(1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0);
    add(1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0);
    // gap tolerance
    add(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    add(1'b1, 1'b1, 5'h05, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    add(1'b1, 1'b1, 5'h05, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0);
    // full alignment cycle: bytes on symbols 2,4,5,7,8
    add(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd1, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd1, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd2, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd3, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd3, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd4, 1'b0);
    add(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 8'hFF, 4'd5, 1'b0);
    add(1'b1, 1'b1, 5'h05, 1'b1, 1'b1, 8'hFF, 4'd4, 1'b0);
    add(1'b1, 1'b1, 5'h05, 1'b0, 1'b1, 8'hFF, 4'd5, 1'b0);
    foreach (v[i]) begin
      step(v[i].rn, v[i].me, v[i].d, v[i].r);
      chk($sformatf("vec%0d rdy", i), 32'(rdy), 32'(v[i].e_rdy));
      chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(v[i].e_dout));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(v[i].e_lvl));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(v[i].e_ovf));
    end
    // overflow: 26 symbols = 16 bytes into an 8-deep FIFO, 9th push on symbol 15
    step(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 26; i++) begin
      step(1'b1, 1'b1, 5'(i * 7 + 3), 1'b0);
      chk_model($sformatf("ovf sym%0d", i + 1));
      if (i == 13) chk("ovf before 9th push", 32'(ovf), 32'd0);
      if (i == 14) chk("ovf at 9th push", 32'(ovf), 32'd1);
    end
    chk("ovf saturated level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'h00, 1'b1);
      chk_model($sformatf("ovf drain%0d", i));
    end
    chk("ovf drained rdy", 32'(rdy), 32'd0);
    // full FIFO with a pop on the edge a byte completes
    step(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 5'(i * 3 + 1), 1'b0);
    chk("full level", 32'(level), 32'd8);
    chk_model("full");
    step(1'b1, 1'b1, 5'h11, 1'b1);
    chk("full pop level", 32'(level), 32'd8);
    chk("full pop ovf", 32'(ovf), 32'd0);
    chk_model("full pop");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'h00, 1'b1);
      chk_model($sformatf("full drain%0d", i));
    end
    // long random stream with bursty backpressure
    step(1'b0, 1'b0, 5'h00, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      step(1'b1, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
           $urandom_range(0, 99) < ((k / 500) % 2 == 0 ? 30 : 80));
      chk_model($sformatf("rand%0d", k));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
